// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Summary  : Round-robin arbiter with a registered one-hot grant and index.
//            The owner keeps the grant until it drops its request. Define
//            RR_HOLD_LIMIT_EN to bound consecutive grant cycles to MAX_HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           hold_timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (N < 2 || N > 16 || (N & (N - 1)) != 0 || MAX_HOLD < 1 || MAX_HOLD > 255)
    begin : g_bad_params
        $error("rr_arbiter: parameter out of range");
    end

    logic [0:0]     r_state,    w_state_nxt;
    logic [IDW-1:0] r_ptr,      w_ptr_nxt;
    logic [N-1:0]   r_grant,    w_grant_nxt;
    logic [IDW-1:0] r_grant_id, w_grant_id_nxt;
    logic           r_valid,    w_valid_nxt;
    logic           r_timeout,  w_timeout_nxt;

    logic           w_found;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_idx;

`ifdef RR_HOLD_LIMIT_EN
    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
`endif

    // Scan from the pointer upward; N is a power of two so IDW-bit wrap is mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = r_ptr + IDW'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_valid_nxt    = r_valid;
        w_timeout_nxt  = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_nxt    = {{(N-1){1'b0}}, 1'b1} << w_win;
                    w_grant_id_nxt = w_win;
                    w_valid_nxt    = 1'b1;
                    w_ptr_nxt      = w_win + IDW'(1);
`ifdef RR_HOLD_LIMIT_EN
                    w_hold_cnt_nxt = 8'd1;
`endif
                end
            end
            S_GRANT: begin
                if (!req[r_grant_id]) begin
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_valid_nxt    = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
                    w_hold_cnt_nxt = 8'd0;
                end else if (r_hold_cnt == c_max_hold) begin
                    // Forced release; ptr already points past this owner.
                    w_state_nxt    = S_IDLE;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                    w_valid_nxt    = 1'b0;
                    w_timeout_nxt  = 1'b1;
                    w_hold_cnt_nxt = 8'd0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
            r_hold_cnt <= 8'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_valid    <= w_valid_nxt;
            r_timeout  <= w_timeout_nxt;
`ifdef RR_HOLD_LIMIT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
`endif
        end
    end

    assign grant        = r_grant;
    assign grant_id     = r_grant_id;
    assign grant_valid  = r_valid;
    assign hold_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter
// Summary  : Self-checking bench for rr_arbiter; per-cycle expectations are
//            queued with the stimulus and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter;

    localparam int N   = 8;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic           hold_timeout;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           timeout;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_id     (grant_id),
        .grant_valid  (grant_valid),
        .hold_timeout (hold_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_no, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue what the outputs must be after the edge.
    task automatic cyc(input logic [N-1:0] r, input logic rs, input logic v,
                       input int id, input logic to);
        exp_t         e;
        logic [N-1:0] eg;
        req = r;
        rst = rs;
        e.valid   = v;
        e.id      = v ? IDW'(id) : '0;
        e.timeout = to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        check_value("sb_depth", 32'(sb_q.size()), 32'd1);
        e  = sb_q.pop_front();
        eg = e.valid ? (N'(1) << e.id) : '0;
        check_value("grant",        32'(grant),        32'(eg));
        check_value("grant_id",     32'(grant_id),     32'(e.id));
        check_value("grant_valid",  32'(grant_valid),  32'(e.valid));
        check_value("hold_timeout", 32'(hold_timeout), 32'(e.timeout));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc_no);
        $fatal(1, "watchdog expired");
    end

    initial begin
        req = '0;
        rst = 1'b1;

        // Reset with all requests high, then first grant goes to index 0.
        cyc(8'hFF, 1'b1, 1'b0, 0, 1'b0);
        cyc(8'hFF, 1'b1, 1'b0, 0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b1, 0, 1'b0);

        // Rotation through all requesters and back to 0.
        for (int k = 0; k < 8; k++) begin
            cyc(8'hFF, 1'b0, 1'b1, k, 1'b0);
            cyc(8'hFF & ~(8'h01 << k), 1'b0, 1'b0, 0, 1'b0);
            cyc(8'hFF, 1'b0, 1'b1, (k + 1) % 8, 1'b0);
        end
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);

`ifndef RR_HOLD_LIMIT_EN
        // Unbounded hold; a later request from 2 waits for the owner.
        cyc(8'h10, 1'b0, 1'b1, 4, 1'b0);
        for (int c = 1; c < 50; c++)
            cyc((c >= 20) ? 8'h14 : 8'h10, 1'b0, 1'b1, 4, 1'b0);
        cyc(8'h04, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h04, 1'b0, 1'b1, 2, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);
`endif

        // Pointer wrap: owner 7 leaves ptr=0, then 0 wins, then 7 wins.
        cyc(8'h80, 1'b0, 1'b1, 7, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h81, 1'b0, 1'b1, 0, 1'b0);
        cyc(8'h80, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h81, 1'b0, 1'b1, 7, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);

        // Reset mid-grant clears the pointer.
        cyc(8'h20, 1'b0, 1'b1, 5, 1'b0);
        cyc(8'h20, 1'b0, 1'b1, 5, 1'b0);
        cyc(8'h20, 1'b1, 1'b0, 0, 1'b0);
        cyc(8'h21, 1'b0, 1'b1, 0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);

        // Single-cycle pulse still gets a one-cycle grant (ptr=1 here).
        cyc(8'h08, 1'b0, 1'b1, 3, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);

`ifdef RR_HOLD_LIMIT_EN
        // ptr=4: requester 2 wins, times out after 4 cycles, 3 takes over.
        for (int c = 0; c < 4; c++) cyc(8'h0C, 1'b0, 1'b1, 2, 1'b0);
        cyc(8'h0C, 1'b0, 1'b0, 0, 1'b1);
        for (int c = 0; c < 4; c++) cyc(8'h0C, 1'b0, 1'b1, 3, 1'b0);
        cyc(8'h0C, 1'b0, 1'b0, 0, 1'b1);
        for (int c = 0; c < 4; c++) cyc(8'h0C, 1'b0, 1'b1, 2, 1'b0);
        // Voluntary release on the limit edge is not a timeout.
        cyc(8'h08, 1'b0, 1'b0, 0, 1'b0);
        cyc(8'h08, 1'b0, 1'b1, 3, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
